multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Moore/Mealy main control FSM for the multicycle MIPS datapath.
- Decodes Op (and Funct for jr) from the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback.
- Drives ALUOp into the ALU control decoder (00 add, 01 sub, 10 R-format, 11 and/zero-extend) and all datapath mux selects and write enables.
- Handshakes with a variable-latency unified memory via mem_ready.

Parameters:
- OP_RTYPE, 6'd0, R-format opcode
- OP_LW, 6'd35, load word
- OP_SW, 6'd43, store word
- OP_BEQ, 6'd4, branch if equal
- OP_J, 6'd2, jump
- OP_ADDI, 6'd8, add immediate
- OP_ANDI, 6'd12, and immediate (zero-extended)
- JR_FUNCT, 6'd8, jr function code

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- Op  input  6  IR[31:26]
- Funct  input  6  IR[5:0]
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite  output  1  unconditional PC write
- PCWriteCond  output  1  PC write if ALU Zero
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  load instruction register
- MemtoReg  output  1  1 = MDR to register file
- PCSource  output  2  00 ALU, 01 ALUOut, 10 jump target, 11 register A
- ALUOp  output  2  to ALU control
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 B, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2
- RegWrite  output  1  register file write
- RegDst  output  1  1 = rd, 0 = rt
- state  output  4  current state, debug
- illegal_op  output  1  registered one-cycle pulse on unknown opcode

Behaviour:
- Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JR 12. Codes 13-15 are unreachable and go to FETCH on the next edge.
- Reset: on the edge with reset=1, state <= FETCH and illegal_op <= 0.
- While reset=1, PCWrite, PCWriteCond, MemWrite, IRWrite and RegWrite are forced to 0 combinationally.
- Outputs default to 0 unless listed for the current state.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00.
  - IRWrite=PCWrite=mem_ready (Mealy).
  - Stay while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcB=11, ALUOp=00. Next state:
  - Op=0 with Funct=8 -> JR; Op=0 otherwise -> EXEC.
  - lw or sw -> MEMADR; beq -> BRANCH; j -> JUMP; addi or andi -> IEXEC.
  - Any other Op -> FETCH, with illegal_op=1 in the following cycle only.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEMRD if Op=lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1, held high until mem_ready. Then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegWrite=1, RegDst=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- JR: PCWrite=1, PCSource=11, ALUOp=10 so the ALU control asserts jr. No RegWrite. Next FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi (selects zero-extend). Next IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- Op and Funct are sampled only in DECODE, MEMADR and IEXEC; the IR holds them stable in those states.
- CPI with zero wait states: lw 5, sw/R/addi/andi 4, beq/j/jr 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset mid-instruction (e.g. in MEMWR with MemWrite=1): the next cycle is FETCH with no write enables asserted during reset.

Test Plan:
- Reset for 2 cycles with mem_ready=1 -> state=0, all write enables 0 during reset; first cycle after release has IRWrite=PCWrite=1.
- Op=35, mem_ready=1 throughout -> states 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 only in state 4.
- Op=43, mem_ready low for 3 cycles in MEMWR -> MemWrite stays 1 for 4 cycles, then state 0; RegWrite never 1.
- Op=0 Funct=32 -> states 0,1,6,7 with ALUOp=10 in 6; RegDst=1 and RegWrite=1 in 7. Then Funct=8 -> states 0,1,12 with PCSource=11, PCWrite=1, RegWrite=0.
- Op=12 -> ALUOp=11 in IEXEC; Op=8 -> ALUOp=00; both write rt in IWB. Op=4 -> PCWriteCond=1, ALUOp=01, PCSource=01 in state 8.
- Op=6'd63 -> DECODE returns to FETCH; illegal_op=1 for exactly one cycle, no write enables asserted.

Source files
------------

// File: rtl/multicycle_main_control.sv
// +--------------------------------------------------------------------------+
// | multicycle_main_control: main control FSM for a multicycle MIPS datapath |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter logic [5:0] OP_ADDI  = 6'd8,
  parameter logic [5:0] OP_ANDI  = 6'd12,
  parameter logic [5:0] JR_FUNCT = 6'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11,
    JR     = 4'd12
  } state_t;

  state_t cur_state;

  assign state = cur_state;

  // Next-state sequencing and the registered illegal-opcode pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (cur_state)
        FETCH: begin
          if (mem_ready) cur_state <= DECODE;
        end
        DECODE: begin
          if (Op == OP_RTYPE) begin
            cur_state <= (Funct == JR_FUNCT) ? JR : EXEC;
          end else if (Op == OP_LW || Op == OP_SW) begin
            cur_state <= MEMADR;
          end else if (Op == OP_BEQ) begin
            cur_state <= BRANCH;
          end else if (Op == OP_J) begin
            cur_state <= JUMP;
          end else if (Op == OP_ADDI || Op == OP_ANDI) begin
            cur_state <= IEXEC;
          end else begin
            cur_state  <= FETCH;
            illegal_op <= 1'b1;
          end
        end
        MEMADR: cur_state <= (Op == OP_LW) ? MEMRD : MEMWR;
        MEMRD: begin
          if (mem_ready) cur_state <= MEMWB;
        end
        MEMWB:  cur_state <= FETCH;
        MEMWR: begin
          if (mem_ready) cur_state <= FETCH;
        end
        EXEC:   cur_state <= RWB;
        RWB:    cur_state <= FETCH;
        BRANCH: cur_state <= FETCH;
        JUMP:   cur_state <= FETCH;
        IEXEC:  cur_state <= IWB;
        IWB:    cur_state <= FETCH;
        JR:     cur_state <= FETCH;
        default: cur_state <= FETCH;
      endcase
    end
  end

  logic pc_write_raw;
  logic pc_write_cond_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;

  // Datapath controls decoded from the current state; FETCH is Mealy on mem_ready.
  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    IorD              = 1'b0;
    MemRead           = 1'b0;
    MemtoReg          = 1'b0;
    PCSource          = 2'b00;
    ALUOp             = 2'b00;
    ALUSrcA           = 1'b0;
    ALUSrcB           = 2'b00;
    RegDst            = 1'b0;
    case (cur_state)
      FETCH: begin
        MemRead      = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
      end
      MEMWR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
      end
      BRANCH: begin
        ALUSrcA           = 1'b1;
        ALUOp             = 2'b01;
        pc_write_cond_raw = 1'b1;
        PCSource          = 2'b01;
      end
      JUMP: begin
        pc_write_raw = 1'b1;
        PCSource     = 2'b10;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (Op == OP_ANDI) ? 2'b11 : 2'b00;
      end
      IWB: begin
        reg_write_raw = 1'b1;
      end
      JR: begin
        pc_write_raw = 1'b1;
        PCSource     = 2'b11;
        ALUOp        = 2'b10;
      end
      default: begin
      end
    endcase
  end

  // Architectural write enables are suppressed for the whole reset interval.
  assign PCWrite     = pc_write_raw      & ~reset;
  assign PCWriteCond = pc_write_cond_raw & ~reset;
  assign MemWrite    = mem_write_raw     & ~reset;
  assign IRWrite     = ir_write_raw      & ~reset;
  assign RegWrite    = reg_write_raw     & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
// Directed testbench for multicycle_main_control: per-cycle state and control-word checks.
`default_nettype none

module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0] state;

  int tests  = 0;
  int failed = 0;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Control word: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  // PCSource[1:0],ALUOp[1:0],ALUSrcA,ALUSrcB[1:0],RegWrite,RegDst
  logic [15:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; Op = 6'd0; Funct = 6'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (state !== 4'd0 || ctrl !== 16'h1004 || illegal_op !== 1'b0) begin
        failed++;
        $display("FAIL reset cyc%0d: state=%0d ctrl=%h ill=%b, want state=0 ctrl=1004 ill=0",
                 i, state, ctrl, illegal_op);
      end
    end
    reset = 1'b0;
    #1;
    tests++;
    if (state !== 4'd0 || ctrl !== 16'h9404) begin
      failed++;
      $display("FAIL reset_release: state=%0d ctrl=%h, want state=0 ctrl=9404", state, ctrl);
    end
    // Leave the bench in FETCH, one tick later re-entered fresh
    mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    logic [3:0]  es[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [15:0] ec[5] = '{16'h9404, 16'h000C, 16'h0018, 16'h3000, 16'h0202};
    Op = 6'd35; Funct = 6'd0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #1;
      tests++;
      if (state !== es[i] || ctrl !== ec[i] || illegal_op !== 1'b0) begin
        failed++;
        $display("FAIL lw cyc%0d: state=%0d ctrl=%h ill=%b, want state=%0d ctrl=%h ill=0",
                 i, state, ctrl, illegal_op, es[i], ec[i]);
      end
      tick();
    end
    tests++;
    if (state !== 4'd0) begin
      failed++;
      $display("FAIL lw_end: state=%0d, want 0", state);
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  es[6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4};
    logic [15:0] ec[6] = '{16'h9404, 16'h000C, 16'h0018, 16'h3000, 16'h3000, 16'h0202};
    logic        mr[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    Op = 6'd35;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i]; #1;
      tests++;
      if (state !== es[i] || ctrl !== ec[i] || illegal_op !== 1'b0) begin
        failed++;
        $display("FAIL lw_wait cyc%0d: state=%0d ctrl=%h ill=%b, want state=%0d ctrl=%h ill=0",
                 i, state, ctrl, illegal_op, es[i], ec[i]);
      end
      tick();
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  es[7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    logic [15:0] ec[7] = '{16'h9404, 16'h000C, 16'h0018, 16'h2800, 16'h2800, 16'h2800, 16'h2800};
    logic        mr[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    Op = 6'd43;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      tests++;
      if (state !== es[i] || ctrl !== ec[i] || illegal_op !== 1'b0) begin
        failed++;
        $display("FAIL sw_wait cyc%0d: state=%0d ctrl=%h ill=%b, want state=%0d ctrl=%h ill=0",
                 i, state, ctrl, illegal_op, es[i], ec[i]);
      end
      tick();
    end
    tests++;
    if (state !== 4'd0) begin
      failed++;
      $display("FAIL sw_end: state=%0d, want 0", state);
    end
  endtask

  task automatic test_rtype_jr();
    logic [3:0]  es[6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
    logic [15:0] ec[6] = '{16'h1004, 16'h1004, 16'h9404, 16'h000C, 16'h0050, 16'h0003};
    logic        mr[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  js[3] = '{4'd0, 4'd1, 4'd12};
    logic [15:0] jc[3] = '{16'h9404, 16'h000C, 16'h81C0};
    Op = 6'd0; Funct = 6'd32;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i]; #1;
      tests++;
      if (state !== es[i] || ctrl !== ec[i] || illegal_op !== 1'b0) begin
        failed++;
        $display("FAIL rtype cyc%0d: state=%0d ctrl=%h ill=%b, want state=%0d ctrl=%h ill=0",
                 i, state, ctrl, illegal_op, es[i], ec[i]);
      end
      tick();
    end
    Funct = 6'd8;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1; #1;
      tests++;
      if (state !== js[i] || ctrl !== jc[i] || illegal_op !== 1'b0) begin
        failed++;
        $display("FAIL jr cyc%0d: state=%0d ctrl=%h ill=%b, want state=%0d ctrl=%h ill=0",
                 i, state, ctrl, illegal_op, js[i], jc[i]);
      end
      tick();
    end
  endtask

  task automatic test_imm_branch();
    logic [5:0]  ops[4] = '{6'd12, 6'd8, 6'd4, 6'd2};
    logic [3:0]  es[4][4] = '{'{4'd0, 4'd1, 4'd10, 4'd11}, '{4'd0, 4'd1, 4'd10, 4'd11},
                             '{4'd0, 4'd1, 4'd8, 4'd0},   '{4'd0, 4'd1, 4'd9, 4'd0}};
    logic [15:0] ec[4][4] = '{'{16'h9404, 16'h000C, 16'h0078, 16'h0002},
                             '{16'h9404, 16'h000C, 16'h0018, 16'h0002},
                             '{16'h9404, 16'h000C, 16'h40B0, 16'h9404},
                             '{16'h9404, 16'h000C, 16'h8100, 16'h9404}};
    int          len[4] = '{4, 4, 3, 3};
    for (int k = 0; k < 4; k++) begin
      Op = ops[k]; Funct = 6'd0;
      for (int i = 0; i < len[k]; i++) begin
        mem_ready = 1'b1; #1;
        tests++;
        if (state !== es[k][i] || ctrl !== ec[k][i] || illegal_op !== 1'b0) begin
          failed++;
          $display("FAIL op%0d cyc%0d: state=%0d ctrl=%h ill=%b, want state=%0d ctrl=%h ill=0",
                   ops[k], i, state, ctrl, illegal_op, es[k][i], ec[k][i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  es[4] = '{4'd0, 4'd1, 4'd0, 4'd0};
    logic [15:0] ec[4] = '{16'h9404, 16'h000C, 16'h1004, 16'h1004};
    logic        mr[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        ei[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    Op = 6'd63;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i]; #1;
      tests++;
      if (state !== es[i] || ctrl !== ec[i] || illegal_op !== ei[i]) begin
        failed++;
        $display("FAIL illegal cyc%0d: state=%0d ctrl=%h ill=%b, want state=%0d ctrl=%h ill=%b",
                 i, state, ctrl, illegal_op, es[i], ec[i], ei[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    Op = 6'd43;
    mem_ready = 1'b1; tick();
    tick();
    tick();
    mem_ready = 1'b0; #1;
    tests++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      failed++;
      $display("FAIL mid_pre: state=%0d MemWrite=%b, want state=5 MemWrite=1", state, MemWrite);
    end
    reset = 1'b1; #1;
    tests++;
    if (ctrl !== 16'h2000) begin
      failed++;
      $display("FAIL mid_reset_ctrl: ctrl=%h, want 2000", ctrl);
    end
    tick();
    reset = 1'b0; #1;
    tests++;
    if (state !== 4'd0 || ctrl !== 16'h1004 || illegal_op !== 1'b0) begin
      failed++;
      $display("FAIL mid_after: state=%0d ctrl=%h ill=%b, want state=0 ctrl=1004 ill=0",
               state, ctrl, illegal_op);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; Op = 6'd0; Funct = 6'd0;
    test_reset();
    test_lw();
    test_lw_wait();
    test_sw_wait();
    test_rtype_jr();
    test_imm_branch();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
